// File: rtl/axil_csr_slave.sv
// -----------------------------------------------------------------------------
// axil_csr_slave
//
// AXI4-Lite slave that holds the control/status registers of the accelerator
// datapath. It decodes host accesses into configuration outputs, a start pulse
// and a level interrupt for the DMA/crypto engine. It also captures the
// engine's busy level and done pulse.
//
// Register map (decoded on addr[7:2], aliased every 256 bytes):
//   0x00 CTRL     bit0 enable (RW), bit1 start (W1 pulses start_o, reads 0),
//                 bit2 irq_en (RW)
//   0x04 STATUS   bit0 busy (live busy_i), bit1 done (sticky, W1C)
//   0x08 SRC_ADDR RW, byte strobes honoured
//   0x0C DST_ADDR RW, byte strobes honoured
//   0x10 LEN      RW, byte strobes honoured
//   0x14 VERSION  RO
//   other         SLVERR, writes dropped, reads return 0
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   aw*/w*/b*                       AXI-Lite write address/data/response
//   ar*/r*                          AXI-Lite read address/data
//   busy_i, done_i                  engine status (level, one-cycle pulse)
//   enable_o, start_o               CTRL.enable, one-cycle start pulse
//   src_addr_o, dst_addr_o, len_o   configuration registers
//   irq_o                           STATUS.done & CTRL.irq_en
// -----------------------------------------------------------------------------
module axil_csr_slave #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] VERSION    = 32'h2026_0100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  // write response channel
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  // read data channel
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  // engine side
  input  logic                    busy_i,
  input  logic                    done_i,
  output logic                    enable_o,
  output logic                    start_o,
  output logic [DATA_WIDTH-1:0]   src_addr_o,
  output logic [DATA_WIDTH-1:0]   dst_addr_o,
  output logic [DATA_WIDTH-1:0]   len_o,
  output logic                    irq_o
);

  localparam int         NB          = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [5:0] IDX_CTRL    = 6'h00;
  localparam logic [5:0] IDX_STATUS  = 6'h01;
  localparam logic [5:0] IDX_SRC     = 6'h02;
  localparam logic [5:0] IDX_DST     = 6'h03;
  localparam logic [5:0] IDX_LEN     = 6'h04;
  localparam logic [5:0] IDX_VERSION = 6'h05;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // ---------------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------------
  w_state_t              w_state_reg;
  logic                  aw_held_reg;
  logic                  w_held_reg;
  logic [5:0]            aw_idx_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [NB-1:0]         wstrb_reg;
  logic                  awready_reg;
  logic                  wready_reg;
  logic                  bvalid_reg;
  logic [1:0]            bresp_reg;

  // ---------------------------------------------------------------------------
  // Register file state
  // ---------------------------------------------------------------------------
  logic                  enable_reg;
  logic                  irq_en_reg;
  logic                  start_reg;
  logic                  done_reg;
  logic                  done_next;
  logic [DATA_WIDTH-1:0] src_reg, src_next;
  logic [DATA_WIDTH-1:0] dst_reg, dst_next;
  logic [DATA_WIDTH-1:0] len_reg, len_next;

  // ---------------------------------------------------------------------------
  // Read channel state
  // ---------------------------------------------------------------------------
  r_state_t              r_state_reg;
  logic                  arready_reg;
  logic                  rvalid_reg;
  logic [1:0]            rresp_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  rd_err;

  // Only addr[7:2] takes part in decode; the rest is deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[ADDR_WIDTH-1:8], awaddr[1:0],
                              araddr[ADDR_WIDTH-1:8], araddr[1:0]};

  // A write commits on the edge after both halves have been captured.
  logic commit;
  logic wr_ctrl, wr_status, wr_src, wr_dst, wr_len;

  assign commit    = (w_state_reg == W_IDLE) && aw_held_reg && w_held_reg;
  // CTRL/STATUS fields all live in byte 0, so only wstrb[0] matters there.
  assign wr_ctrl   = commit && (aw_idx_reg == IDX_CTRL)   && wstrb_reg[0];
  assign wr_status = commit && (aw_idx_reg == IDX_STATUS) && wstrb_reg[0];
  assign wr_src    = commit && (aw_idx_reg == IDX_SRC);
  assign wr_dst    = commit && (aw_idx_reg == IDX_DST);
  assign wr_len    = commit && (aw_idx_reg == IDX_LEN);

  // ---------------------------------------------------------------------------
  // Write FSM: AW and W are captured independently, then committed together.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg <= W_IDLE;
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      aw_idx_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (aw_held_reg && w_held_reg) begin
            // Both readies are already low here, so no new handshake can land.
            w_state_reg <= W_RESP;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= (aw_idx_reg <= IDX_VERSION) ? RESP_OKAY : RESP_SLVERR;
          end else begin
            if (awvalid && awready_reg) begin
              aw_held_reg <= 1'b1;
              aw_idx_reg  <= awaddr[7:2];
              awready_reg <= 1'b0;
            end else begin
              awready_reg <= !aw_held_reg;
            end
            if (wvalid && wready_reg) begin
              w_held_reg <= 1'b1;
              wdata_reg  <= wdata;
              wstrb_reg  <= wstrb;
              wready_reg <= 1'b0;
            end else begin
              wready_reg <= !w_held_reg;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state_reg <= W_IDLE;
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Byte-lane merge for the three 32-bit configuration registers.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign src_next[gi*8 +: 8] = (wr_src && wstrb_reg[gi]) ? wdata_reg[gi*8 +: 8]
                                                             : src_reg[gi*8 +: 8];
      assign dst_next[gi*8 +: 8] = (wr_dst && wstrb_reg[gi]) ? wdata_reg[gi*8 +: 8]
                                                             : dst_reg[gi*8 +: 8];
      assign len_next[gi*8 +: 8] = (wr_len && wstrb_reg[gi]) ? wdata_reg[gi*8 +: 8]
                                                             : len_reg[gi*8 +: 8];
    end
  endgenerate

  // A done pulse on the same edge as a W1C keeps done set.
  assign done_next = done_i | (done_reg & ~(wr_status & wdata_reg[1]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_reg <= 1'b0;
      irq_en_reg <= 1'b0;
      start_reg  <= 1'b0;
      done_reg   <= 1'b0;
      src_reg    <= '0;
      dst_reg    <= '0;
      len_reg    <= '0;
    end else begin
      if (wr_ctrl) begin
        enable_reg <= wdata_reg[0];
        irq_en_reg <= wdata_reg[2];
      end
      start_reg <= wr_ctrl && wdata_reg[1];
      done_reg  <= done_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      len_reg   <= len_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Read decode. Sampled at the AR handshake, so a write committing on the
  // same edge is not yet visible to that read.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    rd_err = 1'b0;
    case (araddr[7:2])
      IDX_CTRL: begin
        rd_mux[0] = enable_reg;
        rd_mux[2] = irq_en_reg;
      end
      IDX_STATUS: begin
        rd_mux[0] = busy_i;
        rd_mux[1] = done_reg;
      end
      IDX_SRC:     rd_mux = src_reg;
      IDX_DST:     rd_mux = dst_reg;
      IDX_LEN:     rd_mux = len_reg;
      IDX_VERSION: rd_mux = VERSION;
      default:     rd_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      rdata_reg   <= '0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (arvalid && arready_reg) begin
            r_state_reg <= R_DATA;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            rdata_reg   <= rd_mux;
            rresp_reg   <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            r_state_reg <= R_IDLE;
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign awready    = awready_reg;
  assign wready     = wready_reg;
  assign bvalid     = bvalid_reg;
  assign bresp      = bresp_reg;
  assign arready    = arready_reg;
  assign rvalid     = rvalid_reg;
  assign rresp      = rresp_reg;
  assign rdata      = rdata_reg;
  assign enable_o   = enable_reg;
  assign start_o    = start_reg;
  assign src_addr_o = src_reg;
  assign dst_addr_o = dst_reg;
  assign len_o      = len_reg;
  // AND of two registers: no cycle added beyond done/irq_en themselves.
  assign irq_o      = done_reg & irq_en_reg;

endmodule

// File: tb/tb_axil_csr_slave.sv
`timescale 1ns/1ps
module tb_axil_csr_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        busy_i = 1'b0;
  logic        done_i = 1'b0;
  logic        enable_o;
  logic        start_o;
  logic [31:0] src_addr_o;
  logic [31:0] dst_addr_o;
  logic [31:0] len_o;
  logic        irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic [1:0] b_q[$];
  rd_exp_t    r_q[$];

  // snapshot of outputs taken in the first cycle bvalid is high
  int          b_lat;
  logic [31:0] snap_src, snap_len;
  logic        snap_en, snap_start;

  // reference model of the configuration registers
  logic [31:0] m_src = '0;
  logic [31:0] m_dst = '0;
  logic [31:0] m_len = '0;

  axil_csr_slave dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .busy_i(busy_i), .done_i(done_i),
    .enable_o(enable_o), .start_o(start_o),
    .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .len_o(len_o),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200us, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  // Drive AW and W; W may lead AW by w_lead cycles.
  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_fire, w_fire;
    int cnt = 0;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    wvalid  = 1'b1;
    awvalid = (w_lead == 0);
    while (!(aw_done && w_done) && cnt < 40) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk); #1;
      cnt++;
      if (aw_fire) begin aw_done = 1; awvalid = 1'b0; end
      if (w_fire)  begin w_done  = 1; wvalid  = 1'b0; end
      if (w_done && !aw_done && !awvalid && cnt >= w_lead) awvalid = 1'b1;
    end
    n_cmp++;
    if (!(aw_done && w_done)) begin
      n_bad++;
      $display("FAIL aw_w_handshake: aw_done=%0b w_done=%0b, required 1/1 within 40 cycles",
               aw_done, w_done);
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
  endtask

  // Wait for the write response, stall bready for b_stall cycles, then accept.
  task automatic collect_b(input int b_stall);
    logic [1:0] exp_resp;
    bready = 1'b0;
    b_lat  = 0;
    while (!bvalid && b_lat < 20) begin
      @(posedge clk); #1;
      b_lat++;
    end
    snap_src   = src_addr_o;
    snap_len   = len_o;
    snap_en    = enable_o;
    snap_start = start_o;
    n_cmp++;
    if (!bvalid) begin
      n_bad++;
      $display("FAIL bvalid_timeout: bvalid=0, required 1 within 20 cycles");
      if (b_q.size() > 0) void'(b_q.pop_front());
      return;
    end
    for (int i = 0; i < b_stall; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bvalid !== 1'b1) begin
        n_bad++;
        $display("FAIL bvalid_hold: stall cycle %0d bvalid=%b, required 1", i, bvalid);
      end
    end
    exp_resp = b_q.pop_front();
    n_cmp++;
    if (bresp !== exp_resp) begin
      n_bad++;
      $display("FAIL bresp: got %0d, required %0d", bresp, exp_resp);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL bvalid_drop: bvalid=%b after B handshake, required 0", bvalid);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp,
                           input int w_lead, input int b_stall);
    logic [5:0] idx;
    idx = addr[7:2];
    b_q.push_back(exp_resp);
    if (idx == 6'h02) m_src = merge(m_src, data, strb);
    if (idx == 6'h03) m_dst = merge(m_dst, data, strb);
    if (idx == 6'h04) m_len = merge(m_len, data, strb);
    send_aw_w(addr, data, strb, w_lead);
    collect_b(b_stall);
    $display("WR addr=%h data=%h strb=%h expected_bresp=%0d latency=%0d",
             addr, data, strb, exp_resp, b_lat);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int r_stall);
    rd_exp_t     e;
    int          cnt = 0;
    logic [31:0] first;
    r_q.push_back('{exp_data, exp_resp});
    araddr  = addr;
    arvalid = 1'b1;
    while (!arready && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_cmp++;
    if (!arready) begin
      n_bad++;
      $display("FAIL ar_timeout: arready=0, required 1 within 20 cycles");
      arvalid = 1'b0;
      void'(r_q.pop_front());
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    // rvalid must already be up the cycle after the AR handshake
    n_cmp++;
    if (rvalid !== 1'b1 || arready !== 1'b0) begin
      n_bad++;
      $display("FAIL r_latency: rvalid=%b arready=%b one cycle after AR, required 1/0",
               rvalid, arready);
      cnt = 0;
      while (!rvalid && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
    end
    first = rdata;
    for (int i = 0; i < r_stall; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== first) begin
        n_bad++;
        $display("FAIL r_hold: rvalid=%b arready=%b rdata=%h, required 1/0/%h",
                 rvalid, arready, rdata, first);
      end
    end
    e = r_q.pop_front();
    n_cmp++;
    if (rdata !== e.data || rresp !== e.resp) begin
      n_bad++;
      $display("FAIL read addr=%h: rdata=%h rresp=%0d, required rdata=%h rresp=%0d",
               addr, rdata, rresp, e.data, e.resp);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rvalid_drop: rvalid=%b after R handshake, required 0", rvalid);
    end
    $display("RD addr=%h expected_data=%h expected_rresp=%0d", addr, e.data, e.resp);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_handshake: aw/w/ar ready,bvalid,rvalid=%b, required 00000",
               {awready, wready, arready, bvalid, rvalid});
    end
    n_cmp++;
    if (bresp !== 2'b0 || rresp !== 2'b0 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_resp: bresp=%0d rresp=%0d rdata=%h, required 0/0/0",
               bresp, rresp, rdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_bad++;
      $display("FAIL ready_after_reset: aw/w/ar ready=%b, required 111",
               {awready, wready, arready});
    end
    n_cmp++;
    if ({enable_o, start_o, irq_o, bvalid, rvalid} !== 5'b0 ||
        src_addr_o !== 0 || dst_addr_o !== 0 || len_o !== 0) begin
      n_bad++;
      $display("FAIL reset_outputs: en/start/irq/bvalid/rvalid=%b src=%h dst=%h len=%h, required all 0",
               {enable_o, start_o, irq_o, bvalid, rvalid}, src_addr_o, dst_addr_o, len_o);
    end
  endtask

  task automatic test_write_read();
    axi_write(32'h08, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0);
    n_cmp++;
    if (b_lat != 1 || snap_src !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL write_src: latency=%0d src=%h at first bvalid, required 1/deadbeef",
               b_lat, snap_src);
    end
    axi_read(32'h08, m_src, 2'b00, 2);
  endtask

  task automatic test_w_before_aw();
    axi_write(32'h10, 32'h1234_5678, 4'b0011, 2'b00, 3, 4);
    n_cmp++;
    if (b_lat != 1 || snap_len !== 32'h0000_5678 || len_o !== m_len) begin
      n_bad++;
      $display("FAIL w_before_aw_len: latency=%0d len=%h, required 1/00005678", b_lat, snap_len);
    end
  endtask

  task automatic test_ctrl_status();
    axi_write(32'h00, 32'h7, 4'hF, 2'b00, 0, 0);
    n_cmp++;
    if (snap_en !== 1'b1 || snap_start !== 1'b1 || start_o !== 1'b0 || enable_o !== 1'b1) begin
      n_bad++;
      $display("FAIL ctrl_start: en=%b start@b=%b start_next=%b, required 1/1/0",
               snap_en, snap_start, start_o);
    end
    axi_read(32'h00, 32'h5, 2'b00, 0);
    axi_read(32'h04, 32'h0, 2'b00, 0);
    busy_i = 1'b1;
    axi_read(32'h04, 32'h1, 2'b00, 0);
    busy_i = 1'b0;
    done_i = 1'b1;
    @(posedge clk); #1;
    done_i = 1'b0;
    n_cmp++;
    if (irq_o !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_set: irq_o=%b, required 1", irq_o);
    end
    axi_read(32'h04, 32'h2, 2'b00, 0);
    // W1C commits on the second edge; done_i is pulsed into that same edge
    fork
      axi_write(32'h04, 32'h2, 4'hF, 2'b00, 0, 0);
      begin
        @(posedge clk); #1;
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
      end
    join
    axi_read(32'h04, 32'h2, 2'b00, 0);
    n_cmp++;
    if (irq_o !== 1'b1) begin
      n_bad++;
      $display("FAIL done_set_wins: irq_o=%b, required 1", irq_o);
    end
    axi_write(32'h04, 32'h2, 4'hF, 2'b00, 0, 0);
    axi_read(32'h04, 32'h0, 2'b00, 0);
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL done_clear: irq_o=%b, required 0", irq_o);
    end
    // byte 0 not strobed: CTRL untouched, no start
    axi_write(32'h00, 32'h0, 4'b1110, 2'b00, 0, 0);
    n_cmp++;
    if (snap_start !== 1'b0 || enable_o !== 1'b1) begin
      n_bad++;
      $display("FAIL ctrl_strobe: start=%b enable=%b, required 0/1", snap_start, enable_o);
    end
    // start pulses even with enable being cleared
    axi_write(32'h00, 32'h2, 4'hF, 2'b00, 0, 0);
    n_cmp++;
    if (snap_start !== 1'b1 || snap_en !== 1'b0) begin
      n_bad++;
      $display("FAIL start_indep: start=%b enable=%b, required 1/0", snap_start, snap_en);
    end
  endtask

  task automatic test_decode();
    axi_read(32'h14, 32'h2026_0100, 2'b00, 0);
    axi_read(32'h18, 32'h0, 2'b10, 0);
    axi_write(32'h1C, 32'hFFFF_FFFF, 4'hF, 2'b10, 0, 0);
    n_cmp++;
    if (src_addr_o !== m_src || dst_addr_o !== m_dst || len_o !== m_len) begin
      n_bad++;
      $display("FAIL slverr_write: src=%h dst=%h len=%h, required %h/%h/%h",
               src_addr_o, dst_addr_o, len_o, m_src, m_dst, m_len);
    end
    axi_write(32'h14, 32'h0, 4'hF, 2'b00, 0, 0);
    axi_read(32'h14, 32'h2026_0100, 2'b00, 0);
    axi_read(32'h108, m_src, 2'b00, 0);
    axi_read(32'h0B, m_src, 2'b00, 0);
  endtask

  task automatic test_concurrent();
    logic [31:0] old_dst;
    old_dst = m_dst;
    // AR handshake lands on the write's commit edge
    fork
      axi_write(32'h0C, 32'hCAFE_F00D, 4'hF, 2'b00, 0, 0);
      begin
        @(posedge clk); #1;
        axi_read(32'h0C, old_dst, 2'b00, 0);
      end
    join
    axi_read(32'h0C, m_dst, 2'b00, 0);
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    b_q.push_back(2'b00);
    send_aw_w(32'h08, 32'h1111_2222, 4'hF, 0);
    bready = 1'b0;
    while (!bvalid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_cmp++;
    if (!bvalid) begin
      n_bad++;
      $display("FAIL mid_reset_bvalid: bvalid=0, required 1 before reset");
    end
    #2;
    rst_n = 1'b0;
    #1;
    // pending response is discarded along with all register state
    b_q.delete();
    m_src = '0;
    m_dst = '0;
    m_len = '0;
    n_cmp++;
    if (bvalid !== 1'b0 || awready !== 1'b0 || src_addr_o !== 32'h0 ||
        dst_addr_o !== 32'h0 || len_o !== 32'h0 || enable_o !== 1'b0 || irq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_clear: bvalid=%b awready=%b src=%h dst=%h len=%h en=%b irq=%b, required all 0",
               bvalid, awready, src_addr_o, dst_addr_o, len_o, enable_o, irq_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({awready, wready, arready, bvalid} !== 4'b1110) begin
      n_bad++;
      $display("FAIL post_reset_ready: aw/w/ar ready,bvalid=%b, required 1110",
               {awready, wready, arready, bvalid});
    end
    axi_read(32'h08, m_src, 2'b00, 0);
    axi_read(32'h00, 32'h0, 2'b00, 0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_ctrl_status();
    test_decode();
    test_concurrent();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
